// File: rtl/famicom_pkg.sv
// Shared definitions for the Famicom controller responder: button layout,
// frame length and the responder state encoding.
package famicom_pkg;

  localparam int NUM_BUTTONS = 8;
  localparam int IDX_W       = 4;

  // Bit positions of each button within joy_buttons / the shifted byte
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } pad_state_t;

endpackage

// File: rtl/famicom_pad_responder_if.sv
// Pad-side bundle: button inputs, Gigatron latch/pulse strobes and the
// serial data plus frame status returned to the host.
interface famicom_pad_responder_if;
  import famicom_pkg::*;

  logic [NUM_BUTTONS-1:0] joy_buttons;
  logic                   famicom_latch;
  logic                   famicom_pulse;
  logic                   famicom_data;
  logic                   frame_done;
  logic [IDX_W-1:0]       bit_index;

  modport master (
    output joy_buttons, famicom_latch, famicom_pulse,
    input  famicom_data, frame_done, bit_index
  );

  modport slave (
    input  joy_buttons, famicom_latch, famicom_pulse,
    output famicom_data, frame_done, bit_index
  );

endinterface

// File: rtl/famicom_pad_responder_sync_edge.sv
// N-flop synchronizer for an asynchronous strobe followed by registered
// rising/falling edge flags (each flag is a single-cycle pulse).
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;
  logic              rise_reg;
  logic              fall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      prev_reg <= sync_reg[STAGES-1];
      rise_reg <= sync_reg[STAGES-1] & ~prev_reg;
      fall_reg <= ~sync_reg[STAGES-1] & prev_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/famicom_pad_responder.sv
// Emulates a 4021-based Famicom pad: latches the buttons on the Gigatron
// latch strobe and shifts them out MSB-first (A first) on each pulse edge.
module famicom_pad_responder
  import famicom_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic FILL_BIT    = 1'b0
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  famicom_pad_responder_if.slave  pad
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUTTONS - 1);

  logic latch_rise;
  logic latch_fall;
  logic pulse_rise;
  logic pulse_fall_unused;

  pad_state_t             state_reg, state_next;
  logic [NUM_BUTTONS-1:0] shift_reg, shift_next;
  logic [NUM_BUTTONS-1:0] shifted;
  logic                   data_reg, data_next;
  logic                   done_reg, done_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;

  sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .din   (pad.famicom_latch),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .din   (pad.famicom_pulse),
    .rise  (pulse_rise),
    .fall  (pulse_fall_unused)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      shift_reg <= '1;
      data_reg  <= 1'b1;
      done_reg  <= 1'b0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      idx_reg   <= idx_next;
    end
  end

  // A latch rising edge aborts whatever frame is in progress; a latch
  // falling edge in LOAD outranks a simultaneous pulse edge.
  always_comb begin
    state_next = state_reg;
    if (latch_rise) begin
      state_next = LOAD;
    end else begin
      unique case (state_reg)
        IDLE:    state_next = IDLE;
        LOAD:    if (latch_fall) state_next = SHIFT;
        SHIFT:   if (pulse_rise && idx_reg == LAST_IDX) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_next = shift_reg;
    data_next  = data_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    shifted    = {shift_reg[NUM_BUTTONS-2:0], FILL_BIT};
    if (latch_rise) begin
      shift_next = ~pad.joy_buttons;
      data_next  = ~pad.joy_buttons[BTN_A];
      idx_next   = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          data_next = 1'b1;
          idx_next  = '0;
        end
        // Transparent while latched; the last load before the fall is kept
        LOAD: begin
          shift_next = ~pad.joy_buttons;
          data_next  = ~pad.joy_buttons[BTN_A];
          idx_next   = '0;
        end
        SHIFT: begin
          if (pulse_rise) begin
            shift_next = shifted;
            data_next  = shifted[NUM_BUTTONS-1];
            idx_next   = idx_reg + IDX_W'(1);
            done_next  = (idx_reg == LAST_IDX);
          end
        end
        DONE:    data_next = FILL_BIT;
        default: data_next = 1'b1;
      endcase
    end
  end

  assign pad.famicom_data = data_reg;
  assign pad.frame_done   = done_reg;
  assign pad.bit_index    = idx_reg;

endmodule

// File: tb/tb_famicom_pad_responder.sv
// Bench for famicom_pad_responder: directed protocol scenarios plus randomly
// phased frames, all checked every cycle against a frame-level model.
module tb_famicom_pad_responder;
  import famicom_pkg::*;

  localparam int   SYNC_STAGES = 2;
  localparam logic FILL_BIT    = 1'b0;
  localparam int   NUM_FRAMES  = 1000;
  localparam int   HALF        = 80;  // half period of the 6.25 MHz host domain
  localparam int   HIST        = SYNC_STAGES + 3;
  localparam int   D           = SYNC_STAGES + 1;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  famicom_pad_responder_if pad_if ();

  famicom_pad_responder #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILL_BIT    (FILL_BIT)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .pad     (pad_if)
  );

  always #10 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  // Frame-level model: host strobes seen SYNC_STAGES+2 cycles late,
  // mode 0 = waiting for latch, 1 = latched, 2 = shifting/shifted out.
  bit   lat_hist[$];
  bit   pul_hist[$];
  int   m_mode;
  int   m_count;
  logic [7:0] m_cap;
  bit   m_done;
  bit   lr, lf, pr;

  function automatic logic exp_data();
    if (m_mode == 0) return 1'b1;
    if (m_mode == 1) return m_cap[7];
    if (m_count < 8) return m_cap[7 - m_count];
    return FILL_BIT;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lat_hist.delete();
      pul_hist.delete();
      for (int i = 0; i < HIST; i++) begin
        lat_hist.push_back(1'b0);
        pul_hist.push_back(1'b0);
      end
      m_mode  = 0;
      m_count = 0;
      m_cap   = 8'hFF;
      m_done  = 1'b0;
    end else begin
      lat_hist.push_front(pad_if.famicom_latch);
      pul_hist.push_front(pad_if.famicom_pulse);
      void'(lat_hist.pop_back());
      void'(pul_hist.pop_back());
      lr = lat_hist[D] && !lat_hist[D+1];
      lf = !lat_hist[D] && lat_hist[D+1];
      pr = pul_hist[D] && !pul_hist[D+1];
      m_done = 1'b0;
      if (lr) begin
        m_mode  = 1;
        m_count = 0;
        m_cap   = ~pad_if.joy_buttons;
      end else if (m_mode == 1) begin
        m_cap = ~pad_if.joy_buttons;
        if (lf) m_mode = 2;
      end else if (m_mode == 2 && pr && m_count < 8) begin
        m_count++;
        m_done = (m_count == 8);
      end
    end
  end

  always @(posedge clk_sys) begin
    #2;
    check("cyc_data", 16'(pad_if.famicom_data), 16'(exp_data()));
    check("cyc_index", 16'(pad_if.bit_index), 16'(m_count));
    check("cyc_done", 16'(pad_if.frame_done), 16'(m_done));
    if (pad_if.frame_done === 1'b1) done_seen++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic pulse_once();
    pad_if.famicom_pulse = 1'b1;
    cyc(4);
    pad_if.famicom_pulse = 1'b0;
    cyc(4);
  endtask

  task automatic latch_frame(input logic [7:0] joy);
    pad_if.joy_buttons   = joy;
    pad_if.famicom_latch = 1'b1;
    cyc(4);
    pad_if.famicom_latch = 1'b0;
    cyc(5);
  endtask

  bit seq28 [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
  int d0;

  initial begin
    pad_if.joy_buttons   = 8'h00;
    pad_if.famicom_latch = 1'b0;
    pad_if.famicom_pulse = 1'b0;
    cyc(3);
    check("reset_data", 16'(pad_if.famicom_data), 16'd1);
    check("reset_index", 16'(pad_if.bit_index), 16'd0);
    check("reset_done", 16'(pad_if.frame_done), 16'd0);
    reset_n = 1'b1;
    cyc(2);

    // A + Right
    latch_frame(8'h81);
    check("a_right_bit0", 16'(pad_if.famicom_data), 16'd0);
    d0 = done_seen;
    for (int k = 0; k < 8; k++) begin
      pulse_once();
      $display("a_right pulse %0d data=%0d index=%0d", k + 1, pad_if.famicom_data, pad_if.bit_index);
      check("a_right_data", 16'(pad_if.famicom_data), 16'(seq28[k]));
      check("a_right_index", 16'(pad_if.bit_index), 16'(k + 1));
    end
    check("a_right_done_once", 16'(done_seen - d0), 16'd1);

    // Relatch mid-frame
    latch_frame(8'hFF);
    repeat (3) pulse_once();
    check("abort_index_before", 16'(pad_if.bit_index), 16'd3);
    d0 = done_seen;
    pad_if.famicom_latch = 1'b1;
    cyc(4);
    check("abort_index", 16'(pad_if.bit_index), 16'd0);
    check("abort_data", 16'(pad_if.famicom_data), 16'd0);
    pad_if.famicom_latch = 1'b0;
    cyc(5);
    check("abort_no_done", 16'(done_seen - d0), 16'd0);

    // Latch fall and pulse rise together
    pad_if.joy_buttons   = 8'h40;
    pad_if.famicom_latch = 1'b1;
    cyc(4);
    pad_if.famicom_latch = 1'b0;
    pad_if.famicom_pulse = 1'b1;
    cyc(4);
    pad_if.famicom_pulse = 1'b0;
    cyc(4);
    check("tie_a_kept", 16'(pad_if.famicom_data), 16'd1);
    check("tie_index", 16'(pad_if.bit_index), 16'd0);
    pulse_once();
    check("tie_b_bit", 16'(pad_if.famicom_data), 16'd0);
    check("tie_b_index", 16'(pad_if.bit_index), 16'd1);

    // Over-clocking past the frame
    latch_frame(8'h00);
    d0 = done_seen;
    for (int k = 1; k <= 12; k++) begin
      pulse_once();
      check("over_data", 16'(pad_if.famicom_data), (k < 8) ? 16'd1 : 16'(FILL_BIT));
      check("over_index", 16'(pad_if.bit_index), (k < 8) ? 16'(k) : 16'd8);
    end
    check("over_done_once", 16'(done_seen - d0), 16'd1);

    // Reset mid-shift
    latch_frame(8'h5A);
    repeat (5) pulse_once();
    check("rst_index_before", 16'(pad_if.bit_index), 16'd5);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check("rst_data_now", 16'(pad_if.famicom_data), 16'd1);
    check("rst_index_now", 16'(pad_if.bit_index), 16'd0);
    cyc(3);
    reset_n = 1'b1;
    repeat (3) pulse_once();
    check("rst_idle_index", 16'(pad_if.bit_index), 16'd0);
    check("rst_idle_data", 16'(pad_if.famicom_data), 16'd1);
    latch_frame(8'h5A);
    pulse_once();
    check("rst_relatch_b", 16'(pad_if.famicom_data), 16'd0);
    check("rst_relatch_index", 16'(pad_if.bit_index), 16'd1);

    // Randomly phased host-domain frames; joy changes mid-frame are ignored
    d0 = done_seen;
    for (int f = 0; f < NUM_FRAMES; f++) begin
      @(negedge clk_sys);
      #($urandom_range(0, 9) * 2 + 1);
      pad_if.joy_buttons   = 8'($urandom);
      pad_if.famicom_latch = 1'b1;
      #HALF;
      pad_if.famicom_latch = 1'b0;
      #HALF;
      for (int b = 0; b < 8; b++) begin
        pad_if.famicom_pulse = 1'b1;
        if ($urandom_range(0, 3) == 0) pad_if.joy_buttons = 8'($urandom);
        #HALF;
        pad_if.famicom_pulse = 1'b0;
        #HALF;
      end
    end
    cyc(10);
    check("random_frames_done", 16'(done_seen - d0), 16'(NUM_FRAMES));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
